myprotocol_rx: RTL
==================

MYPROTOCOL_RX -- requirements
Module: myprotocol_rx

Interface
REQ-001 SHALL have parameter DATA_W, default 8, the number of payload bits per frame.
REQ-002 SHALL have parameter TIMEOUT, default 15, the maximum consecutive sig1-low cycles allowed mid-frame.
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port sig1  input  1  bit-enable; sig2 is valid when high.
REQ-006 SHALL have port sig2  input  1  serial data, MSB first.
REQ-007 SHALL have port sig3  input  1  start marker, one-cycle pulse.
REQ-008 SHALL have port rx_data  output  DATA_W  last received payload, held until the next frame completes.
REQ-009 SHALL have port rx_valid  output  1  one-cycle pulse on frame completion.
REQ-010 SHALL have port parity_err  output  1  one-cycle pulse coincident with rx_valid on even-parity mismatch.
REQ-011 SHALL have port frame_err  output  1  one-cycle pulse on abort (restart or timeout).
REQ-012 SHALL have port frame_cnt  output  8  count of good frames, wrapping.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement the states IDLE, DATA, PARITY and DONE.
REQ-015 IDLE SHALL move to DATA on sig3=1 and ignore sig1 and sig2 otherwise.
REQ-016 DATA SHALL sample sig2 into the shift register on each sig1=1 cycle (bit counter +1); after DATA_W samples it SHALL move to PARITY.
REQ-017 PARITY SHALL sample sig2 on the next sig1=1 cycle as the even-parity bit and SHALL then move to DONE.
REQ-018 DONE SHALL last exactly one cycle, in which rx_valid=1, rx_data updates and parity_err=(XOR of payload and parity bit); the next state SHALL be IDLE, or DATA if sig3=1 in that cycle.
REQ-019 Latency SHALL be: rx_valid high in the cycle immediately after the clock edge that sampled the final bit.
REQ-020 frame_cnt SHALL increment in DONE only when parity_err=0, and SHALL wrap from 255 to 0.
REQ-021 Gaps (sig1=0) inside DATA or PARITY SHALL stall reception without error while the gap counter is at or below TIMEOUT.
REQ-022 The gap counter SHALL clear on every sig1=1 cycle.
REQ-023 On TIMEOUT+1 consecutive gap cycles the block SHALL pulse frame_err, go to IDLE and leave rx_data unchanged.
REQ-024 sig3=1 in DATA or PARITY SHALL pulse frame_err, clear the bit counter and remain in (or re-enter) DATA as a fresh frame; the sig1 sample in that same cycle SHALL be discarded.
REQ-025 When sig3=1 and the timeout expire in the same cycle, the restart SHALL win, with a single frame_err pulse.

Reset
REQ-026 rst=0 SHALL asynchronously force IDLE, rx_data=0, rx_valid=0, parity_err=0, frame_err=0, frame_cnt=0, busy=0, and clear the bit and gap counters.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame and produce no pulses.
REQ-028 After rst returns high, the first sig3 SHALL be honoured on the first rising clk edge.

Configuration
REQ-029 Macro MYPROTOCOL_RX_PARITY_EN SHALL control parity handling.
REQ-030 With MYPROTOCOL_RX_PARITY_EN defined: PARITY state present, frame length DATA_W+1 bits.
REQ-031 Without MYPROTOCOL_RX_PARITY_EN: DATA SHALL move directly to DONE after DATA_W bits, parity_err SHALL be tied 0, and every completed frame SHALL increment frame_cnt.

Structure
REQ-032 Package myprotocol_pkg SHALL hold the state enum, the default DATA_W and TIMEOUT constants, and the frame_cnt width; the transmitter shares the package.
REQ-033 Sub-module myprotocol_rx_gap_timer SHALL hold the gap counter and TIMEOUT compare, outputting a one-cycle expire pulse; the FSM, shift register and bit counter stay in myprotocol_rx.

Verification
REQ-034 Bench SHALL check: sig3 pulse, then 9 back-to-back sig1 cycles with data 0xA5 and parity 0 -> rx_valid in cycle 11 after sig3, rx_data=0xA5, parity_err=0, frame_cnt=1.
REQ-035 Bench SHALL check: same frame with parity bit 1 -> rx_valid=1, parity_err=1, rx_data=0xA5, frame_cnt unchanged.
REQ-036 Bench SHALL check: 4 bits sent, then sig1 low for 16 cycles -> frame_err in gap cycle 16, busy=0, rx_data unchanged; a 15-cycle gap instead produces no error and 0x3C still decodes.
REQ-037 Bench SHALL check: sig3 re-pulsed after 5 bits, then a full 0x0F frame -> exactly one frame_err, then rx_data=0x0F.
REQ-038 Bench SHALL check: rst driven low between clk edges mid-frame -> outputs 0 immediately; a following 0x81 frame decodes with frame_cnt=1.
REQ-039 Bench SHALL check: 256 good frames -> frame_cnt reads 0; without MYPROTOCOL_RX_PARITY_EN, an 8-bit 0xFF frame -> rx_valid in cycle 10 after sig3.

Source files
------------

// File: rtl/myprotocol_pkg.sv
// Shared definitions for the myprotocol receiver and transmitter.
package myprotocol_pkg;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_TIMEOUT = 15;
  localparam int FRAME_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_DONE   = 2'd3
  } state_t;
endpackage

// File: rtl/myprotocol_rx_gap_timer.sv
// Counts consecutive sig1-low cycles inside a frame; pulses expire on gap cycle TIMEOUT+1.
module myprotocol_rx_gap_timer
  import myprotocol_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  input  logic sig1,
  output logic expire
);
  localparam int CW = $clog2(TIMEOUT + 2);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  cnt <= '0;
    else if (!en || clr || sig1) cnt <= '0;
    else                       cnt <= cnt + CW'(1);
  end

  // cnt holds the gaps already seen, so this cycle is gap number cnt+1
  assign expire = en & ~clr & ~sig1 & (cnt == CW'(TIMEOUT));
endmodule

// File: rtl/myprotocol_rx.sv
// Serial frame receiver: sig3 start, sig1-qualified sig2 bits MSB first, optional even parity.
// Build option: define MYPROTOCOL_RX_PARITY_EN to receive a trailing parity bit per frame.
module myprotocol_rx
  import myprotocol_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sig1,
  input  logic                   sig2,
  input  logic                   sig3,
  output logic [DATA_W-1:0]      rx_data,
  output logic                   rx_valid,
  output logic                   parity_err,
  output logic                   frame_err,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   busy
);
  localparam int BW = $clog2(DATA_W + 1);

  state_t            state, state_nxt;
  logic [DATA_W-1:0] shreg;
  logic [BW-1:0]     bitcnt;
  logic              expire, abort, sample, load, in_frame;

  assign in_frame = (state == ST_DATA) || (state == ST_PARITY);

  myprotocol_rx_gap_timer #(.TIMEOUT(TIMEOUT)) u_gap (
    .clk    (clk),
    .rst    (rst),
    .en     (in_frame),
    .clr    (sig3),
    .sig1   (sig1),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // restart is checked before expire so a coincident timeout yields one abort
  always_comb begin
    state_nxt = state;
    abort     = 1'b0;
    sample    = 1'b0;
    load      = 1'b0;
    case (state)
      ST_IDLE: if (sig3) state_nxt = ST_DATA;
      ST_DATA: begin
        if (sig3) begin
          abort     = 1'b1;
          state_nxt = ST_DATA;
        end else if (expire) begin
          abort     = 1'b1;
          state_nxt = ST_IDLE;
        end else if (sig1) begin
          sample = 1'b1;
          if (bitcnt == BW'(DATA_W - 1)) begin
`ifdef MYPROTOCOL_RX_PARITY_EN
            state_nxt = ST_PARITY;
`else
            state_nxt = ST_DONE;
            load      = 1'b1;
`endif
          end
        end
      end
`ifdef MYPROTOCOL_RX_PARITY_EN
      ST_PARITY: begin
        if (sig3) begin
          abort     = 1'b1;
          state_nxt = ST_DATA;
        end else if (expire) begin
          abort     = 1'b1;
          state_nxt = ST_IDLE;
        end else if (sig1) begin
          state_nxt = ST_DONE;
          load      = 1'b1;
        end
      end
`endif
      ST_DONE: state_nxt = sig3 ? ST_DATA : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg     <= '0;
      bitcnt    <= '0;
      rx_data   <= '0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
    end else begin
      frame_err <= abort;
      if (sig3)        bitcnt <= '0;
      else if (sample) bitcnt <= bitcnt + BW'(1);
      if (sample) shreg <= {shreg[DATA_W-2:0], sig2};
      if (load) begin
`ifdef MYPROTOCOL_RX_PARITY_EN
        rx_data <= shreg;
`else
        rx_data <= {shreg[DATA_W-2:0], sig2};
`endif
      end
      if (state == ST_DONE && !parity_err) frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
    end
  end

`ifdef MYPROTOCOL_RX_PARITY_EN
  logic perr_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      perr_q <= 1'b0;
    else if (load) perr_q <= ^{shreg, sig2};
    else           perr_q <= 1'b0;
  end
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign rx_valid = (state == ST_DONE);
  assign busy     = (state != ST_IDLE);
endmodule
